// File: rtl/melody_pkg.sv
// melody_pkg: shared types and melody tables for the melody sequencer.
//   state_t  - sequencer FSM states
//   note_t   - one ROM entry {tone, len}; len = 0 ends a melody
//   song_t   - melody index (0 launch, 1 hit, 2 pig destroyed, 3 level win)
//   SONGn    - eight entries per melody, entry 0 in the low byte
//   top_req  - highest set request bit as a song index
package melody_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    typedef logic [1:0] song_t;

    typedef struct packed {
        logic [3:0] tone;
        logic [3:0] len;
    } note_t;

    localparam logic [7:0][7:0] SONG0 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h41, 8'h02};
    // The "hit" event is deliberately silent: an empty melody.
    localparam logic [7:0][7:0] SONG1 = '0;
    localparam logic [7:0][7:0] SONG2 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB1, 8'h92, 8'h71};
    // Level win fills all eight slots, so it ends on pointer exhaustion rather than len = 0.
    localparam logic [7:0][7:0] SONG3 = {8'hC1, 8'hD1, 8'hE1, 8'hF1, 8'hF1, 8'hE1, 8'hD1, 8'hC1};

    function automatic song_t top_req(input logic [3:0] req);
        return req[3] ? 2'd3 : req[2] ? 2'd2 : req[1] ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// melody_rom: combinational lookup of one note entry.
//   song    - melody index
//   pointer - entry index within the melody (0..7)
//   note    - {tone, len} at that position
module melody_rom
    import melody_pkg::*;
(
    input  song_t      song,
    input  logic [2:0] pointer,
    output note_t      note
);

    assign note = note_t'(song == 2'd3 ? SONG3[pointer] :
                          song == 2'd2 ? SONG2[pointer] :
                          song == 2'd1 ? SONG1[pointer] : SONG0[pointer]);

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays prioritised game-event melodies as timed note/gap sequences.
//   clk         - system clock
//   resetN      - asynchronous active-low reset
//   soundReq    - one-cycle event requests, higher index wins
//   tone        - registered note index for the tone decoder
//   enableSound - registered, high only while a note sounds
//   busy        - registered, high while a melody runs and for the cycle it returns to IDLE
//   activeSong  - registered index of the current/last melody
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int UNIT_CYCLES = 1_575_000,
    parameter int GAP_UNITS   = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] soundReq,
    output logic [3:0] tone,
    output logic       enableSound,
    output logic       busy,
    output song_t      activeSong
);

    localparam int              CW       = UNIT_CYCLES > 1 ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0]   CYC_LAST = CW'(UNIT_CYCLES - 1);
    localparam logic [3:0]      GAP_LOAD = 4'(GAP_UNITS);

    state_t        state, state_n;
    logic [2:0]    pointer, pointer_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [3:0]    units, units_n, tone_n;
    song_t         song_n, req_song;
    note_t         note;
    logic          req_any, preempt, unit_wrap, expire;

    melody_rom rom (
        .song    (activeSong),
        .pointer (pointer),
        .note    (note)
    );

    assign req_any   = |soundReq;
    assign req_song  = top_req(soundReq);
    assign preempt   = req_any && state != IDLE && req_song > activeSong;
    assign unit_wrap = cyc == CYC_LAST;
    assign expire    = unit_wrap && units <= 4'd1;

    always_comb begin
        state_n   = state;
        pointer_n = pointer;
        cyc_n     = cyc;
        units_n   = units;
        tone_n    = tone;
        song_n    = activeSong;
        if (preempt) begin
            state_n   = LOAD;
            pointer_n = '0;
            song_n    = req_song;
        end else begin
            case (state)
                // busy still set means this is the cycle we just returned: drop the request.
                IDLE: if (req_any && !busy) begin
                    state_n   = LOAD;
                    pointer_n = '0;
                    song_n    = req_song;
                end
                LOAD: if (note.len == 4'd0) begin
                    state_n = IDLE;
                end else begin
                    state_n = PLAY;
                    tone_n  = note.tone;
                    units_n = note.len;
                    cyc_n   = '0;
                end
                PLAY: begin
                    cyc_n   = unit_wrap ? '0 : cyc + 1'b1;
                    units_n = expire ? GAP_LOAD : unit_wrap ? units - 4'd1 : units;
                    state_n = expire ? GAP : PLAY;
                end
                GAP: begin
                    cyc_n     = unit_wrap ? '0 : cyc + 1'b1;
                    units_n   = unit_wrap ? units - 4'd1 : units;
                    state_n   = !expire ? GAP : pointer == 3'd7 ? IDLE : LOAD;
                    pointer_n = expire && pointer != 3'd7 ? pointer + 3'd1 : pointer;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            pointer     <= '0;
            cyc         <= '0;
            units       <= '0;
            tone        <= '0;
            enableSound <= 1'b0;
            busy        <= 1'b0;
            activeSong  <= '0;
        end else begin
            state       <= state_n;
            pointer     <= pointer_n;
            cyc         <= cyc_n;
            units       <= units_n;
            tone        <= tone_n;
            enableSound <= state_n == PLAY;
            busy        <= state != IDLE || state_n != IDLE;
            activeSong  <= song_n;
        end
    end

endmodule
